// File: rtl/fft_pkg.sv
// fft_pkg: shared widths and lane-packing helpers for the FFT twiddle stage.
// Build option: TWIDDLE_CMULT_SAT_EN (consumed by the stage modules, not here).
package fft_pkg;

    // Width of one packed complex lane (real in the upper half, imag below).
    function automatic int slice_w(input int nbits);
        return 2 * nbits;
    endfunction

    // Width of a full real x real product.
    function automatic int prod_w(input int nbits);
        return 2 * nbits;
    endfunction

    // Width of a sum/difference of two products, no loss.
    function automatic int sum_w(input int nbits);
        return 2 * nbits + 1;
    endfunction

    // MSB index of lane k on an n-lane bus; lane 0 sits at the top.
    function automatic int lane_msb(input int k, input int n, input int nbits);
        return (n - k) * slice_w(nbits) - 1;
    endfunction

    localparam int DEF_NBITS     = 11;
    localparam int DEF_COEF_FRAC = 9;
    localparam int LANE_W        = slice_w(DEF_NBITS);
    localparam int PROD_W        = prod_w(DEF_NBITS);
    localparam int SUM_W         = sum_w(DEF_NBITS);

endpackage

// File: rtl/twiddle_cmult_stage_if.sv
// twiddle_cmult_stage_if: vector in/out bundle of the twiddle multiplier stage.
// master drives samples/coefficients, slave is the stage itself.
// Build option: TWIDDLE_CMULT_SAT_EN (o_ovf is constant 0 when undefined).
interface twiddle_cmult_stage_if #(
    parameter int NBITS = fft_pkg::DEF_NBITS,
    parameter int N     = 32
) ();
    localparam int DW = N * 2 * NBITS;

    logic          i_enable;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic [DW-1:0] i_coeff;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_sof;
    logic          o_ovf;

    modport master (
        output i_enable, i_valid, i_data, i_coeff,
        input  o_valid, o_data, o_sof, o_ovf
    );

    modport slave (
        input  i_enable, i_valid, i_data, i_coeff,
        output o_valid, o_data, o_sof, o_ovf
    );
endinterface

// File: rtl/cmult_lane.sv
// cmult_lane: one complex lane, y = x * c, three registered stages
// (operands, products, rounded/reduced result).
// Build option: TWIDDLE_CMULT_SAT_EN selects saturation and exposes o_ovf;
// without it results wrap to NBITS and there is no overflow output.
module cmult_lane
    import fft_pkg::*;
#(
    parameter int NBITS     = DEF_NBITS,
    parameter int COEF_FRAC = DEF_COEF_FRAC
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_enable,
    input  logic [slice_w(NBITS)-1:0] i_x,
    input  logic [slice_w(NBITS)-1:0] i_c,
`ifdef TWIDDLE_CMULT_SAT_EN
    output logic                      o_ovf,
`endif
    output logic [slice_w(NBITS)-1:0] o_y
);
    localparam int LW = slice_w(NBITS);
    localparam int PW = prod_w(NBITS);
    localparam int SW = sum_w(NBITS);
    localparam logic signed [SW-1:0] RND = SW'(1) <<< (COEF_FRAC - 1);

    logic signed [NBITS-1:0] xr_q, xi_q, cr_q, ci_q;
    logic signed [NBITS-1:0] xr_d, xi_d, cr_d, ci_d;
    logic signed [PW-1:0]    p_rr_q, p_ii_q, p_ri_q, p_ir_q;
    logic signed [PW-1:0]    p_rr_d, p_ii_d, p_ri_d, p_ir_d;
    logic [LW-1:0]           y_q, y_d;
    logic signed [SW-1:0]    sum_re, sum_im, sh_re, sh_im;
    logic [NBITS-1:0]        red_re, red_im;

    // Combine S2 products, round half up and drop the coefficient fraction.
    always_comb begin
        sum_re = SW'(p_rr_q) - SW'(p_ii_q);
        sum_im = SW'(p_ri_q) + SW'(p_ir_q);
        sh_re  = (sum_re + RND) >>> COEF_FRAC;
        sh_im  = (sum_im + RND) >>> COEF_FRAC;
    end

`ifdef TWIDDLE_CMULT_SAT_EN
    localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (NBITS - 1)) - 1);
    localparam logic signed [SW-1:0] MIN_V = SW'(-(2 ** (NBITS - 1)));

    // Clamp each rounded component to the NBITS range and flag any clamp.
    always_comb begin
        red_re = sh_re[NBITS-1:0];
        red_im = sh_im[NBITS-1:0];
        o_ovf  = 1'b0;
        if (sh_re > MAX_V) begin
            red_re = MAX_V[NBITS-1:0];
            o_ovf  = 1'b1;
        end else if (sh_re < MIN_V) begin
            red_re = MIN_V[NBITS-1:0];
            o_ovf  = 1'b1;
        end
        if (sh_im > MAX_V) begin
            red_im = MAX_V[NBITS-1:0];
            o_ovf  = 1'b1;
        end else if (sh_im < MIN_V) begin
            red_im = MIN_V[NBITS-1:0];
            o_ovf  = 1'b1;
        end
    end
`else
    // Upper bits are deliberately discarded by the two's-complement wrap.
    logic unused_hi;
    assign unused_hi = ^{sh_re[SW-1:NBITS], sh_im[SW-1:NBITS]};

    // Wrap each rounded component to its low NBITS bits.
    always_comb begin
        red_re = sh_re[NBITS-1:0];
        red_im = sh_im[NBITS-1:0];
    end
`endif

    // Next state for all three stages; everything holds while enable is low.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        xr_d   = xr_q;
        xi_d   = xi_q;
        cr_d   = cr_q;
        ci_d   = ci_q;
        p_rr_d = p_rr_q;
        p_ii_d = p_ii_q;
        p_ri_d = p_ri_q;
        p_ir_d = p_ir_q;
        y_d    = y_q;
        if (i_enable) begin
            xr_d   = i_x[LW-1:NBITS];
            xi_d   = i_x[NBITS-1:0];
            cr_d   = i_c[LW-1:NBITS];
            ci_d   = i_c[NBITS-1:0];
            p_rr_d = PW'(xr_q) * PW'(cr_q);
            p_ii_d = PW'(xi_q) * PW'(ci_q);
            p_ri_d = PW'(xr_q) * PW'(ci_q);
            p_ir_d = PW'(xi_q) * PW'(cr_q);
            y_d    = {red_re, red_im};
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        // NOTE: datapath registers are reset as well, so o_data reads 0 right after reset.
        if (i_reset) begin
            xr_q   <= '0;
            xi_q   <= '0;
            cr_q   <= '0;
            ci_q   <= '0;
            p_rr_q <= '0;
            p_ii_q <= '0;
            p_ri_q <= '0;
            p_ir_q <= '0;
            y_q    <= '0;
        end else begin
            // NOTE: <= makes every stage sample pre-edge values, which is what forms the pipeline.
            xr_q   <= xr_d;
            xi_q   <= xi_d;
            cr_q   <= cr_d;
            ci_q   <= ci_d;
            p_rr_q <= p_rr_d;
            p_ii_q <= p_ii_d;
            p_ri_q <= p_ri_d;
            p_ir_q <= p_ir_d;
            y_q    <= y_d;
        end
    end

    assign o_y = y_q;

endmodule

// File: rtl/twiddle_cmult_stage.sv
// twiddle_cmult_stage: N-lane pipelined complex multiplier applying the stage
// twiddles to butterfly outputs, latency 3 enabled cycles, with frame tracking.
// Build option: TWIDDLE_CMULT_SAT_EN enables saturation and the sticky o_ovf.
module twiddle_cmult_stage
    import fft_pkg::*;
#(
    parameter int NBITS     = DEF_NBITS,
    parameter int N         = 32,
    parameter int COEF_FRAC = DEF_COEF_FRAC,
    parameter int FRAME_LEN = 4
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    twiddle_cmult_stage_if.slave bus
);
    localparam int LW = slice_w(NBITS);
    localparam int CW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_LEN - 1);

    logic          v1_q, v1_d, v2_q, v2_d;
    logic          valid_q, valid_d, sof_q, sof_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N*LW-1:0] data_out;
`ifdef TWIDDLE_CMULT_SAT_EN
    logic [N-1:0]  lane_ovf;
    logic          ovf_q, ovf_d;
`endif

    for (genvar k = 0; k < N; k++) begin : g_lane
        localparam int MSB = lane_msb(k, N, NBITS);
        cmult_lane #(
            .NBITS     (NBITS),
            .COEF_FRAC (COEF_FRAC)
        ) u_lane (
            .i_clock  (i_clock),
            .i_reset  (i_reset),
            .i_enable (bus.i_enable),
            .i_x      (bus.i_data[MSB -: LW]),
            .i_c      (bus.i_coeff[MSB -: LW]),
`ifdef TWIDDLE_CMULT_SAT_EN
            .o_ovf    (lane_ovf[k]),
`endif
            .o_y      (data_out[MSB -: LW])
        );
    end

    // Valid pipeline, frame counter, start-of-frame and sticky overflow.
    always_comb begin
        v1_d    = v1_q;
        v2_d    = v2_q;
        valid_d = valid_q;
        sof_d   = sof_q;
        cnt_d   = cnt_q;
`ifdef TWIDDLE_CMULT_SAT_EN
        ovf_d   = ovf_q;
`endif
        if (bus.i_enable) begin
            v1_d    = bus.i_valid;
            v2_d    = v1_q;
            valid_d = v2_q;
            sof_d   = v2_q && (cnt_q == '0);
            if (v2_q) begin
                cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
`ifdef TWIDDLE_CMULT_SAT_EN
            // Only a vector that is actually being presented can raise the flag.
            ovf_d = ovf_q | (v2_q & (|lane_ovf));
`endif
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef TWIDDLE_CMULT_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            v1_q    <= v1_d;
            v2_q    <= v2_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            cnt_q   <= cnt_d;
`ifdef TWIDDLE_CMULT_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.o_valid = valid_q;
    assign bus.o_sof   = sof_q;
    assign bus.o_data  = data_out;
`ifdef TWIDDLE_CMULT_SAT_EN
    assign bus.o_ovf   = ovf_q;
`else
    assign bus.o_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_twiddle_cmult_stage.sv
// tb_twiddle_cmult_stage: table vectors plus stall/frame and mid-stream reset
// sequences, checked through a scoreboard queue against an integer model.
// Build option: TWIDDLE_CMULT_SAT_EN switches the expected overflow behaviour.
module tb_twiddle_cmult_stage;
    localparam int NB = 11;
    localparam int NL = 32;
    localparam int LW = 2 * NB;
    localparam int DW = NL * LW;
    localparam int FL = 4;
    localparam int NROWS = 8;

    typedef struct {
        string name;
        int    xr, xi, cr, ci, er, ei;
        bit    ov;
    } row_t;

    typedef struct {
        string         name;
        logic [DW-1:0] data;
        logic          sof;
        logic          ovf;
        int            cap;
    } exp_t;

    logic i_clock = 1'b0;
    logic i_reset;

    twiddle_cmult_stage_if #(.NBITS(NB), .N(NL)) bus ();

    twiddle_cmult_stage #(
        .NBITS     (NB),
        .N         (NL),
        .COEF_FRAC (9),
        .FRAME_LEN (FL)
    ) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 i_clock = ~i_clock;

    exp_t          sb_q[$];
    exp_t          mon_e;
    bit            mon_due;
    int            n_checks = 0;
    int            n_errors = 0;
    int            en_edges = 0;
    int            frame_idx = 0;
    bit            ovf_model = 1'b0;
    bit            rst_at_edge = 1'b0;
    bit            en_at_edge = 1'b0;
    logic          prev_valid;
    logic [DW-1:0] prev_data;
    row_t          rows[NROWS];
    int            xr[NL], xi[NL], cr[NL], ci[NL], yr[NL], yi[NL];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, DW'(act), DW'(exp));
    endtask

    function automatic int reduce(input int r, output bit ov);
        logic [NB-1:0] t;
        ov = 1'b0;
`ifdef TWIDDLE_CMULT_SAT_EN
        if (r > 1023) begin
            ov = 1'b1;
            return 1023;
        end
        if (r < -1024) begin
            ov = 1'b1;
            return -1024;
        end
        return r;
`else
        t = NB'(r);
        return int'($signed(t));
`endif
    endfunction

    // Reference: exact integer products, floor((s + 0.5 LSB) / 512), then reduce.
    function automatic void ref_cmult(input int a_r, input int a_i, input int b_r, input int b_i,
                                      output int o_r, output int o_i, output bit ov);
        bit ov_r, ov_i;
        o_r = reduce((a_r * b_r - a_i * b_i + 256) >>> 9, ov_r);
        o_i = reduce((a_r * b_i + a_i * b_r + 256) >>> 9, ov_i);
        ov  = ov_r | ov_i;
    endfunction

    function automatic logic [DW-1:0] pack(input int re[NL], input int im[NL]);
        logic [DW-1:0] v;
        v = '0;
        for (int k = 0; k < NL; k++) begin
            v[(NL - k) * LW - 1 -: LW] = {NB'(re[k]), NB'(im[k])};
        end
        return v;
    endfunction

    task automatic drive(input bit en, input bit vld, input logic [DW-1:0] d, input logic [DW-1:0] c);
        @(posedge i_clock);
        #1;
        bus.i_enable = en;
        bus.i_valid  = vld;
        bus.i_data   = d;
        bus.i_coeff  = c;
    endtask

    task automatic send(input string name, input logic [DW-1:0] d, input logic [DW-1:0] c,
                        input logic [DW-1:0] expd, input bit ov);
        exp_t e;
        drive(1'b1, 1'b1, d, c);
        ovf_model = ovf_model | ov;
        e.name = name;
        e.data = expd;
        e.sof  = (frame_idx == 0);
        e.ovf  = ovf_model;
        e.cap  = en_edges + 1;
        frame_idx = (frame_idx + 1) % FL;
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b1, 1'b0, '0, '0);
    endtask

    task automatic do_reset(input bit en);
        @(posedge i_clock);
        #1;
        i_reset      = 1'b1;
        bus.i_enable = en;
        bus.i_valid  = 1'b0;
        frame_idx    = 0;
        ovf_model    = 1'b0;
        @(posedge i_clock);
        #1;
        i_reset      = 1'b0;
        bus.i_enable = 1'b1;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (sb_q.size() > 0 && budget > 0) begin
            idle(1);
            budget--;
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d outputs still pending, expected 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    // Edge bookkeeping: what the DUT saw at this edge.
    always @(posedge i_clock) begin
        rst_at_edge = i_reset;
        en_at_edge  = bus.i_enable;
        if (i_reset) begin
            sb_q.delete();
        end else if (bus.i_enable) begin
            en_edges++;
        end
    end

    // Output monitor, sampling on the falling edge.
    always @(negedge i_clock) begin
        if (rst_at_edge) begin
            check_bit("reset_valid", bus.o_valid, 1'b0);
            check_bit("reset_sof", bus.o_sof, 1'b0);
            check_bit("reset_ovf", bus.o_ovf, 1'b0);
            check("reset_data", bus.o_data, '0);
        end else if (en_at_edge) begin
            mon_due = (sb_q.size() > 0) && (en_edges - sb_q[0].cap >= 2);
            check_bit("o_valid", bus.o_valid, mon_due);
            if (mon_due) begin
                mon_e = sb_q.pop_front();
                check({mon_e.name, "_latency"}, DW'(en_edges - mon_e.cap), DW'(2));
                check({mon_e.name, "_data"}, bus.o_data, mon_e.data);
                check_bit({mon_e.name, "_sof"}, bus.o_sof, mon_e.sof);
                check_bit({mon_e.name, "_ovf"}, bus.o_ovf, mon_e.ovf);
            end else begin
                check_bit("idle_sof", bus.o_sof, 1'b0);
            end
        end else begin
            check_bit("stall_valid", bus.o_valid, prev_valid);
            check("stall_data", bus.o_data, prev_data);
        end
        prev_valid = bus.o_valid;
        prev_data  = bus.o_data;
    end

    initial begin
        rows[0] = '{"passthrough", 300, -200, 512, 0, 300, -200, 1'b0};
        rows[1] = '{"twiddle_re", 512, 0, 502, -100, 502, -100, 1'b0};
        rows[2] = '{"twiddle_im", 0, 512, 502, -100, 100, 502, 1'b0};
        rows[3] = '{"round_up", 1, 0, 256, 0, 1, 0, 1'b0};
        rows[4] = '{"round_neg", -1, 0, 256, 0, 0, 0, 1'b0};
        rows[5] = '{"min_input", -1024, -1024, 512, 0, -1024, -1024, 1'b0};
`ifdef TWIDDLE_CMULT_SAT_EN
        rows[6] = '{"overflow", 1023, 1023, 512, 512, 0, 1023, 1'b1};
        rows[7] = '{"full_scale", -1024, -1024, -1024, -1024, 0, 1023, 1'b1};
`else
        rows[6] = '{"overflow", 1023, 1023, 512, 512, 0, -2, 1'b0};
        rows[7] = '{"full_scale", -1024, -1024, -1024, -1024, 0, 0, 1'b0};
`endif

        i_reset      = 1'b1;
        bus.i_enable = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_data   = '0;
        bus.i_coeff  = '0;
        repeat (2) @(posedge i_clock);
        #1;
        i_reset      = 1'b0;
        bus.i_enable = 1'b1;

        // Table vectors, back to back, same values on every lane.
        for (int i = 0; i < NROWS; i++) begin
            for (int k = 0; k < NL; k++) begin
                xr[k] = rows[i].xr;
                xi[k] = rows[i].xi;
                cr[k] = rows[i].cr;
                ci[k] = rows[i].ci;
                yr[k] = rows[i].er;
                yi[k] = rows[i].ei;
            end
            send(rows[i].name, pack(xr, xi), pack(cr, ci), pack(yr, yi), rows[i].ov);
        end
        drain();

        // Overflow flag stays put once the stream is idle.
        repeat (3) begin
            idle(1);
            @(negedge i_clock);
            check_bit("ovf_sticky", bus.o_ovf, ovf_model);
        end

        // Stall and frame: 8 distinct vectors, enable low for 2 cycles mid-stream.
        do_reset(1'b1);
        for (int v = 0; v < 8; v++) begin
            bit any_ov;
            bit ov;
            if (v == 4) begin
                repeat (2) drive(1'b0, 1'b1, '1, '1);
            end
            any_ov = 1'b0;
            for (int k = 0; k < NL; k++) begin
                xr[k] = int'($urandom_range(2047, 0)) - 1024;
                xi[k] = int'($urandom_range(2047, 0)) - 1024;
                cr[k] = int'($urandom_range(1024, 0)) - 512;
                ci[k] = int'($urandom_range(1024, 0)) - 512;
                ref_cmult(xr[k], xi[k], cr[k], ci[k], yr[k], yi[k], ov);
                any_ov = any_ov | ov;
            end
            send($sformatf("frame_v%0d", v), pack(xr, xi), pack(cr, ci), pack(yr, yi), any_ov);
        end
        drain();

        // Reset mid-stream with two vectors in flight, enable low during reset.
        for (int v = 0; v < 2; v++) begin
            for (int k = 0; k < NL; k++) begin
                xr[k] = 100 + k;
                xi[k] = -k;
                cr[k] = 512;
                ci[k] = 0;
            end
            send("discarded", pack(xr, xi), pack(cr, ci), '0, 1'b0);
        end
        do_reset(1'b0);
        idle(4);
        for (int k = 0; k < NL; k++) begin
            xr[k] = 300;
            xi[k] = -200;
            cr[k] = 512;
            ci[k] = 0;
            yr[k] = 300;
            yi[k] = -200;
        end
        send("after_reset", pack(xr, xi), pack(cr, ci), pack(yr, yi), 1'b0);
        drain();
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
